pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Per cycle it decides which stages advance, freeze, flush or take a bubble, based on load-use hazards, taken branches and data-memory wait states.
- Also generates the EX-stage operand forwarding selects.
- Tracks memory-wait duration with a watchdog and keeps saturating stall/flush counters for debug.

---
 rtl/pipe_hazard_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : pipeline stage sequencer (advance/freeze/flush/bubble), EX forwarding selects,
//           data-memory wait watchdog and saturating stall/flush debug counters.
// Latency : control and forwarding outputs are combinational (same-edge); FSM/counters registered.
// Backpressure: a data-memory wait (freeze) holds every stage and bubbles MEM/WB; after
//           TIMEOUT consecutive wait cycles the block locks in ERR until reset.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   id_rs1addr/id_rs2addr     sources of the instruction in ID
//   id_ex_rdaddr/memread      destination / load flag of the instruction in EX
//   ex_rs1addr/ex_rs2addr     sources of the instruction in EX (forwarding)
//   ex_mem_rdaddr/regwrite    destination / write flag in MEM
//   ex_mem_memop, dmem_ready  MEM data access in flight / completes this cycle
//   mem_wb_rdaddr/regwrite    destination / write flag in WB
//   branch_taken              EX resolved a taken branch or jump
//   pc_en .. ex_mem_en        stage advance enables
//   if_id_flush, id_ex_flush  load a NOP into that stage register
//   mem_wb_bubble             load a NOP into MEM/WB
//   fwd_a, fwd_b              10 = EX/MEM, 01 = MEM/WB, 00 = register file
//   err                       sticky memory-timeout error
//   stall_cnt, flush_cnt      saturating debug counters
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,  // consecutive freeze cycles before ERR, must be >= 2
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1addr,
  input  logic [4:0]       id_rs2addr,
  input  logic [4:0]       id_ex_rdaddr,
  input  logic             id_ex_memread,
  input  logic [4:0]       ex_rs1addr,
  input  logic [4:0]       ex_rs2addr,
  input  logic [4:0]       ex_mem_rdaddr,
  input  logic             ex_mem_regwrite,
  input  logic             ex_mem_memop,
  input  logic             dmem_ready,
  input  logic [4:0]       mem_wb_rdaddr,
  input  logic             mem_wb_regwrite,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic loaduse;
  logic in_err;
  logic stall_apply;
  logic flush_apply;

  // Hazard conditions
  assign freeze  = ex_mem_memop & ~dmem_ready;
  assign loaduse = id_ex_memread & (id_ex_rdaddr != 5'd0) &
                   ((id_ex_rdaddr == id_rs1addr) | (id_ex_rdaddr == id_rs2addr));

  assign in_err = (state_q == ST_ERR);

  // What actually takes effect this cycle: freeze wins over a branch, and a
  // branch squashes the ID instruction, so its load-use stall is not applied.
  assign stall_apply = ~in_err & (freeze | (loaduse & ~branch_taken));
  assign flush_apply = ~in_err & branch_taken & ~freeze;

  // State register (also holds the watchdog and debug counters)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCNT_ONE;
        end
      end
      ST_WAIT: begin
        if (freeze) begin
          // wait_cnt already counts the cycles frozen before this one, so
          // reaching TIMEOUT-1 here means this is the TIMEOUT-th cycle.
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + WCNT_ONE;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Saturating debug counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_apply && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (flush_apply && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // Output logic: control is a function of state and current inputs so the
  // pipeline registers see the decision on the same edge. While rst is low
  // everything is held at its idle value even between clock edges.
  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    err           = 1'b0;
    if (rst) begin
      if (in_err) begin
        mem_wb_bubble = 1'b1;
        err           = 1'b1;
      end else if (freeze) begin
        mem_wb_bubble = 1'b1;
      end else if (branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (loaduse) begin
        // Hold PC and IF/ID, push a bubble into ID/EX, let EX drain.
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
      end
    end
  end

  // Forwarding selects: the younger producer (EX/MEM) takes precedence.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst) begin
      if (ex_mem_regwrite && (ex_mem_rdaddr != 5'd0) && (ex_mem_rdaddr == ex_rs1addr)) begin
        fwd_a = 2'b10;
      end else if (mem_wb_regwrite && (mem_wb_rdaddr != 5'd0) && (mem_wb_rdaddr == ex_rs1addr)) begin
        fwd_a = 2'b01;
      end
      if (ex_mem_regwrite && (ex_mem_rdaddr != 5'd0) && (ex_mem_rdaddr == ex_rs2addr)) begin
        fwd_b = 2'b10;
      end else if (mem_wb_regwrite && (mem_wb_rdaddr != 5'd0) && (mem_wb_rdaddr == ex_rs2addr)) begin
        fwd_b = 2'b01;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1addr, id_rs2addr, id_ex_rdaddr, ex_rs1addr, ex_rs2addr;
  logic [4:0] ex_mem_rdaddr, mem_wb_rdaddr;
  logic id_ex_memread, ex_mem_regwrite, ex_mem_memop, dmem_ready;
  logic mem_wb_regwrite, branch_taken;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble, err;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int fails  = 0;

  // Reference model state: length of the current run of freeze cycles,
  // sticky error, and the two counters as plain integers.
  int m_run   = 0;
  bit m_err   = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr),
    .id_ex_rdaddr(id_ex_rdaddr), .id_ex_memread(id_ex_memread),
    .ex_rs1addr(ex_rs1addr), .ex_rs2addr(ex_rs2addr),
    .ex_mem_rdaddr(ex_mem_rdaddr), .ex_mem_regwrite(ex_mem_regwrite),
    .ex_mem_memop(ex_mem_memop), .dmem_ready(dmem_ready),
    .mem_wb_rdaddr(mem_wb_rdaddr), .mem_wb_regwrite(mem_wb_regwrite),
    .branch_taken(branch_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .err(err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic bit m_freeze();
    return ex_mem_memop && !dmem_ready;
  endfunction

  function automatic bit m_loaduse();
    return id_ex_memread && id_ex_rdaddr != 0 &&
           (id_ex_rdaddr == id_rs1addr || id_ex_rdaddr == id_rs2addr);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (ex_mem_regwrite && ex_mem_rdaddr != 0 && ex_mem_rdaddr == rs) return 2'b10;
    if (mem_wb_regwrite && mem_wb_rdaddr != 0 && mem_wb_rdaddr == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble, err, fwd_a, fwd_b}
  function automatic logic [11:0] exp_ctrl();
    logic [6:0] c;
    if (!rst) return 12'd0;
    if (m_err || m_freeze()) c = 7'b0000001;
    else if (branch_taken)   c = 7'b1111110;
    else if (m_loaduse())    c = 7'b0011010;
    else                     c = 7'b1111000;
    return {c, m_err, m_fwd(ex_rs1addr), m_fwd(ex_rs2addr)};
  endfunction

  function automatic logic [11:0] act_ctrl();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
            mem_wb_bubble, err, fwd_a, fwd_b};
  endfunction

  task automatic model_edge();
    if (rst && !m_err) begin
      if (m_freeze()) begin
        if (m_stall < MAXC) m_stall++;
        m_run++;
        if (m_run == TO) m_err = 1'b1;
      end else begin
        m_run = 0;
        if (branch_taken) begin
          if (m_flush < MAXC) m_flush++;
        end else if (m_loaduse()) begin
          if (m_stall < MAXC) m_stall++;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs1addr = 0; id_rs2addr = 0; id_ex_rdaddr = 0; id_ex_memread = 0;
    ex_rs1addr = 0; ex_rs2addr = 0; ex_mem_rdaddr = 0; ex_mem_regwrite = 0;
    ex_mem_memop = 0; dmem_ready = 1; mem_wb_rdaddr = 0; mem_wb_regwrite = 0;
    branch_taken = 0;
  endtask

  task automatic model_reset();
    m_run = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    model_reset();
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    branch_taken = 1; ex_mem_memop = 1; dmem_ready = 0;
    ex_rs1addr = 3; ex_mem_rdaddr = 3; ex_mem_regwrite = 1;
    #3;
    checks++;
    if (act_ctrl() !== 12'd0) begin
      fails++; $display("FAIL reset_ctrl got %b exp %b", act_ctrl(), 12'd0);
    end
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      fails++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_loaduse();
    do_reset();
    id_ex_memread = 1; id_ex_rdaddr = 5; id_rs2addr = 5; id_rs1addr = 2;
    #1;
    checks++;
    if (act_ctrl() !== 12'b0011010_0_00_00) begin
      fails++; $display("FAIL loaduse_ctrl got %b exp %b", act_ctrl(), 12'b0011010_0_00_00);
    end
    tick();
    checks++;
    if (stall_cnt !== 1) begin
      fails++; $display("FAIL loaduse_stall_cnt got %0d exp 1", stall_cnt);
    end
    id_ex_rdaddr = 0; id_rs2addr = 0;
    #1;
    checks++;
    if (act_ctrl() !== 12'b1111000_0_00_00) begin
      fails++; $display("FAIL loaduse_rd0_ctrl got %b exp %b", act_ctrl(), 12'b1111000_0_00_00);
    end
    tick();
    checks++;
    if (stall_cnt !== 1) begin
      fails++; $display("FAIL loaduse_rd0_cnt got %0d exp 1", stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    id_ex_memread = 1; id_ex_rdaddr = 6; id_rs1addr = 6; branch_taken = 1;
    #1;
    checks++;
    if (act_ctrl() !== 12'b1111110_0_00_00) begin
      fails++; $display("FAIL branch_ctrl got %b exp %b", act_ctrl(), 12'b1111110_0_00_00);
    end
    tick();
    checks++;
    if (flush_cnt !== 1 || stall_cnt !== 0) begin
      fails++; $display("FAIL branch_cnt got %0d/%0d exp 1/0", flush_cnt, stall_cnt);
    end
    ex_mem_memop = 1; dmem_ready = 0;
    #1;
    checks++;
    if (act_ctrl() !== 12'b0000001_0_00_00) begin
      fails++; $display("FAIL branch_freeze_ctrl got %b exp %b", act_ctrl(), 12'b0000001_0_00_00);
    end
    tick();
    checks++;
    if (flush_cnt !== 1 || stall_cnt !== 1) begin
      fails++; $display("FAIL branch_freeze_cnt got %0d/%0d exp 1/1", flush_cnt, stall_cnt);
    end
    set_idle();
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    ex_mem_memop = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (act_ctrl() !== 12'b0000001_0_00_00) begin
        fails++; $display("FAIL memwait_ctrl cyc %0d got %b exp %b", i, act_ctrl(), 12'b0000001_0_00_00);
      end
      tick();
    end
    dmem_ready = 1;
    #1;
    checks++;
    if (act_ctrl() !== 12'b1111000_0_00_00) begin
      fails++; $display("FAIL memwait_done_ctrl got %b exp %b", act_ctrl(), 12'b1111000_0_00_00);
    end
    tick();
    checks++;
    if (stall_cnt !== 3 || err !== 1'b0) begin
      fails++; $display("FAIL memwait_cnt got stall %0d err %b exp 3/0", stall_cnt, err);
    end
    // A fresh run of TO-1 freezes must not trip the watchdog if the wait count cleared.
    dmem_ready = 0;
    for (int i = 0; i < TO - 1; i++) tick();
    dmem_ready = 1;
    #1;
    checks++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL memwait_rerun_err got %b exp 0", err);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    ex_mem_memop = 1; dmem_ready = 0;
    for (int i = 0; i < TO; i++) begin
      #1;
      checks++;
      if (err !== 1'b0) begin
        fails++; $display("FAIL timeout_early_err cyc %0d got %b exp 0", i, err);
      end
      tick();
    end
    dmem_ready = 1; ex_mem_memop = 0; branch_taken = 1;
    #1;
    checks++;
    if (act_ctrl() !== 12'b0000001_1_00_00) begin
      fails++; $display("FAIL timeout_err_ctrl got %b exp %b", act_ctrl(), 12'b0000001_1_00_00);
    end
    tick();
    tick();
    checks++;
    if (err !== 1'b1 || flush_cnt !== 0 || stall_cnt !== TO) begin
      fails++; $display("FAIL timeout_sticky got err %b flush %0d stall %0d exp 1/0/%0d",
                        err, flush_cnt, stall_cnt, TO);
    end
    do_reset();
    checks++;
    if (act_ctrl() !== 12'b1111000_0_00_00) begin
      fails++; $display("FAIL timeout_cleared got %b exp %b", act_ctrl(), 12'b1111000_0_00_00);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    ex_rs1addr = 7; ex_rs2addr = 9; ex_mem_rdaddr = 7; mem_wb_rdaddr = 7;
    ex_mem_regwrite = 1; mem_wb_regwrite = 1;
    #1;
    checks++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
      fails++; $display("FAIL fwd_both got %b/%b exp 10/00", fwd_a, fwd_b);
    end
    ex_mem_regwrite = 0; ex_rs2addr = 7;
    #1;
    checks++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
      fails++; $display("FAIL fwd_memwb got %b/%b exp 01/01", fwd_a, fwd_b);
    end
    ex_mem_regwrite = 1; ex_rs1addr = 0; ex_rs2addr = 0; ex_mem_rdaddr = 0; mem_wb_rdaddr = 0;
    #1;
    checks++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      fails++; $display("FAIL fwd_rd0 got %b/%b exp 00/00", fwd_a, fwd_b);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    ex_mem_memop = 1; dmem_ready = 0;
    tick(); tick();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_ctrl() !== 12'd0 || stall_cnt !== 0) begin
      fails++; $display("FAIL async_reset got %b stall %0d exp 0/0", act_ctrl(), stall_cnt);
    end
    rst = 1'b1;
    #1;
    // If the block restarted in RUN, TO-1 freezes are still short of the limit.
    for (int i = 0; i < TO - 1; i++) tick();
    checks++;
    if (err !== 1'b0 || stall_cnt !== TO - 1) begin
      fails++; $display("FAIL async_reset_run got err %b stall %0d exp 0/%0d", err, stall_cnt, TO - 1);
    end
    set_idle();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    id_ex_memread = 1; id_ex_rdaddr = 4; id_rs1addr = 4;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (stall_cnt !== ((i > MAXC) ? MAXC : i)) begin
        fails++; $display("FAIL sat_stall step %0d got %0d exp %0d", i, stall_cnt, (i > MAXC) ? MAXC : i);
      end
    end
    branch_taken = 1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (flush_cnt !== MAXC || stall_cnt !== MAXC) begin
      fails++; $display("FAIL sat_flush got %0d/%0d exp %0d/%0d", flush_cnt, stall_cnt, MAXC, MAXC);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (act_ctrl() !== 12'd0 || stall_cnt !== 0 || flush_cnt !== 0) begin
          fails++; $display("FAIL rand_reset n=%0d got %b %0d/%0d", n, act_ctrl(), stall_cnt, flush_cnt);
        end
        rst = 1'b1;
      end
      id_rs1addr      = 5'($urandom_range(0, 3));
      id_rs2addr      = 5'($urandom_range(0, 3));
      id_ex_rdaddr    = 5'($urandom_range(0, 3));
      id_ex_memread   = 1'($urandom_range(0, 1));
      ex_rs1addr      = 5'($urandom_range(0, 3));
      ex_rs2addr      = 5'($urandom_range(0, 3));
      ex_mem_rdaddr   = 5'($urandom_range(0, 3));
      mem_wb_rdaddr   = 5'($urandom_range(0, 3));
      ex_mem_regwrite = 1'($urandom_range(0, 1));
      mem_wb_regwrite = 1'($urandom_range(0, 1));
      ex_mem_memop    = ($urandom_range(0, 2) == 0);
      dmem_ready      = 1'($urandom_range(0, 1));
      branch_taken    = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (act_ctrl() !== exp_ctrl()) begin
        fails++; $display("FAIL rand_ctrl n=%0d got %b exp %b", n, act_ctrl(), exp_ctrl());
      end
      tick();
      checks++;
      if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush)) begin
        fails++; $display("FAIL rand_cnt n=%0d got %0d/%0d exp %0d/%0d", n, stall_cnt, flush_cnt, m_stall, m_flush);
      end
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_loaduse();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_forwarding();
    test_async_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
